// File: rtl/obi_arb_pkg.sv
// Shared types and constants for the two-master OBI arbiter.
// The TOUT state only exists when OBI_ARB_TIMEOUT_EN is defined.
package obi_arb_pkg;

`ifdef OBI_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RESP,
        TOUT
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RESP
    } arb_state_e;
`endif

    // Read data returned to the owner when the slave never answers
    localparam logic [31:0] BAD_DATA = 32'hBADCAB1E;

    localparam int unsigned CNT_WIDTH = 8;

endpackage

// File: rtl/obi_rr_arb.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the prio master.
module obi_rr_arb (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = prio;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/obi_arbiter_2.sv
// Two-master to one-slave OBI arbiter, one outstanding transaction at most.
// Define OBI_ARB_TIMEOUT_EN to add a response timeout (TOUT state, TIMEOUT cycles).
module obi_arbiter_2
    import obi_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,

    input  logic [1:0]                     m_req_i,
    output logic [1:0]                     m_gnt_o,
    input  logic [1:0][ADDR_WIDTH-1:0]     m_addr_i,
    input  logic [1:0]                     m_we_i,
    input  logic [1:0][DATA_WIDTH/8-1:0]   m_be_i,
    input  logic [1:0][DATA_WIDTH-1:0]     m_wdata_i,
    output logic [1:0]                     m_rvalid_o,
    input  logic [1:0]                     m_rready_i,
    output logic [DATA_WIDTH-1:0]          m_rdata_o,
    output logic                           m_err_o,

    output logic                           s_req_o,
    input  logic                           s_gnt_i,
    output logic [ADDR_WIDTH-1:0]          s_addr_o,
    output logic                           s_we_o,
    output logic [DATA_WIDTH/8-1:0]        s_be_o,
    output logic [DATA_WIDTH-1:0]          s_wdata_o,
    input  logic                           s_rvalid_i,
    output logic                           s_rready_o,
    input  logic [DATA_WIDTH-1:0]          s_rdata_i,
    input  logic                           s_err_i
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       prio_q, prio_d;
    logic       winner;

`ifdef OBI_ARB_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0]  TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
    localparam logic [DATA_WIDTH-1:0] BAD_RDATA   = DATA_WIDTH'(BAD_DATA);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`else
    logic [CNT_WIDTH-1:0] unused_timeout;
    assign unused_timeout = CNT_WIDTH'(TIMEOUT);
`endif

    obi_rr_arb u_rr_arb (
        .req    (m_req_i),
        .prio   (prio_q),
        .winner (winner)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

`ifdef OBI_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        m_err_o    = 1'b0;
        s_req_o    = 1'b0;
        s_addr_o   = '0;
        s_we_o     = 1'b0;
        s_be_o     = '0;
        s_wdata_o  = '0;
        // Stray slave responses are swallowed whenever no transaction is waiting
        s_rready_o = 1'b1;
`ifdef OBI_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (|m_req_i) begin
                    owner_d = winner;
                    state_d = ADDR;
                end
            end

            ADDR: begin
                s_req_o            = m_req_i[owner_q];
                s_addr_o           = m_addr_i[owner_q];
                s_we_o             = m_we_i[owner_q];
                s_be_o             = m_be_i[owner_q];
                s_wdata_o          = m_wdata_i[owner_q];
                m_gnt_o[owner_q]   = s_gnt_i;
                if (m_req_i[owner_q] && s_gnt_i) begin
                    state_d = RESP;
`ifdef OBI_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (!m_req_i[owner_q]) begin
                    // Owner withdrew before grant: rearbitrate without moving prio
                    state_d = IDLE;
                end
            end

            RESP: begin
                m_rvalid_o[owner_q] = s_rvalid_i;
                s_rready_o          = m_rready_i[owner_q];
                m_rdata_o           = s_rdata_i;
                m_err_o             = s_err_i;
                if (s_rvalid_i && m_rready_i[owner_q]) begin
                    state_d = IDLE;
                    prio_d  = ~owner_q;
                end
`ifdef OBI_ARB_TIMEOUT_EN
                else if (!s_rvalid_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d >= TIMEOUT_CNT) begin
                        state_d = TOUT;
                    end
                end
`endif
            end

`ifdef OBI_ARB_TIMEOUT_EN
            TOUT: begin
                m_rvalid_o[owner_q] = 1'b1;
                m_rdata_o           = BAD_RDATA;
                m_err_o             = 1'b1;
                s_rready_o          = 1'b1;
                if (m_rready_i[owner_q]) begin
                    state_d = IDLE;
                    prio_d  = ~owner_q;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_obi_arbiter_2.sv
// Scoreboard bench for obi_arbiter_2: random masters/slave with a transaction-level model.
module tb_obi_arbiter_2;

    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned BW       = DW / 8;
    localparam int          TOUT_CYC = 4;
    localparam logic [DW-1:0] BAD    = 32'hBADCAB1E;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        int            mst;
        logic [AW-1:0] addr;
        logic          we;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } aexp_t;

    typedef struct {
        int            mst;
        logic [DW-1:0] data;
        logic          err;
    } rexp_t;

    typedef struct {
        int            delay;
        logic [DW-1:0] data;
        logic          err;
        bit            never;
    } splan_t;

    logic                   clk;
    logic                   reset_ni;
    logic [1:0]             m_req_i;
    logic [1:0]             m_gnt_o;
    logic [1:0][AW-1:0]     m_addr_i;
    logic [1:0]             m_we_i;
    logic [1:0][BW-1:0]     m_be_i;
    logic [1:0][DW-1:0]     m_wdata_i;
    logic [1:0]             m_rvalid_o;
    logic [1:0]             m_rready_i;
    logic [DW-1:0]          m_rdata_o;
    logic                   m_err_o;
    logic                   s_req_o;
    logic                   s_gnt_i;
    logic [AW-1:0]          s_addr_o;
    logic                   s_we_o;
    logic [BW-1:0]          s_be_o;
    logic [DW-1:0]          s_wdata_o;
    logic                   s_rvalid_i;
    logic                   s_rready_o;
    logic [DW-1:0]          s_rdata_i;
    logic                   s_err_i;

    obi_arbiter_2 #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TOUT_CYC)
    ) dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .m_req_i    (m_req_i),
        .m_gnt_o    (m_gnt_o),
        .m_addr_i   (m_addr_i),
        .m_we_i     (m_we_i),
        .m_be_i     (m_be_i),
        .m_wdata_i  (m_wdata_i),
        .m_rvalid_o (m_rvalid_o),
        .m_rready_i (m_rready_i),
        .m_rdata_o  (m_rdata_o),
        .m_err_o    (m_err_o),
        .s_req_o    (s_req_o),
        .s_gnt_i    (s_gnt_i),
        .s_addr_o   (s_addr_o),
        .s_we_o     (s_we_o),
        .s_be_o     (s_be_o),
        .s_wdata_o  (s_wdata_o),
        .s_rvalid_i (s_rvalid_i),
        .s_rready_o (s_rready_o),
        .s_rdata_i  (s_rdata_i),
        .s_err_i    (s_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus queues and scoreboard queues
    req_t   mq0[$];
    req_t   mq1[$];
    splan_t sq[$];
    aexp_t  exp_a[$];
    rexp_t  exp_r[$];
    int     glog[$];

    // Transaction-level model: 0 free, 1 address offered, 2 awaiting response, 3 timed out
    int       mphase = 0;
    int       mown   = 0;
    int       pref   = 0;
    int       tcnt   = 0;
    bit [1:0] mwait  = '0;

    bit       s_busy    = 0;
    bit       s_showing = 0;
    bit       late_resp = 0;
    int       s_delay   = 0;
    splan_t   s_cur;

    bit rst_req  = 0;
    bit rand_en  = 0;
    bit abort_en = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic req_t mk_req(input logic [AW-1:0] a, input logic w,
                                    input logic [BW-1:0] b, input logic [DW-1:0] d);
        req_t r;
        r.addr = a; r.we = w; r.be = b; r.wdata = d;
        return r;
    endfunction

    function automatic splan_t mk_plan(input int dly, input logic [DW-1:0] d,
                                       input logic e, input bit nv);
        splan_t p;
        p.delay = dly; p.data = d; p.err = e; p.never = nv;
        return p;
    endfunction

    function automatic req_t rand_req();
        return mk_req($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    endfunction

    function automatic int gl(input int i);
        return (i < glog.size()) ? glog[i] : -1;
    endfunction

    function automatic bit bench_idle();
        return mq0.size() == 0 && mq1.size() == 0 && m_req_i == 2'b00 && mwait == 2'b00 &&
               mphase == 0 && exp_a.size() == 0 && exp_r.size() == 0;
    endfunction

    task automatic finish_txn();
        mphase       = 0;
        pref         = 1 - mown;
        mwait[mown]  = 1'b0;
        s_busy       = 0;
        s_showing    = 0;
    endtask

    // Drive phase: masters and slave choose this cycle's inputs
    task automatic drive();
        req_t r;
        if (rst_req) begin
            rst_req    = 0;
            reset_ni   = 1'b0;
            m_req_i    = '0;
            mwait      = '0;
            mphase     = 0;
            pref       = 0;
            tcnt       = 0;
            s_busy     = 0;
            s_showing  = 0;
            late_resp  = 0;
            s_rvalid_i = 1'b0;
            s_gnt_i    = 1'b0;
            exp_a.delete(); exp_r.delete(); mq0.delete(); mq1.delete(); sq.delete();
            return;
        end
        reset_ni = 1'b1;

        if (rand_en) begin
            if (mq0.size() == 0 && $urandom_range(0, 3) == 0) mq0.push_back(rand_req());
            if (mq1.size() == 0 && $urandom_range(0, 3) == 0) mq1.push_back(rand_req());
        end

        s_gnt_i = 1'($urandom_range(0, 1));
        if (s_busy) begin
            if (!s_showing && !s_cur.never) begin
                if (s_delay > 0) begin
                    s_delay--;
                end else begin
                    rexp_t e;
                    s_showing = 1;
                    e.mst = mown; e.data = s_cur.data; e.err = s_cur.err;
                    exp_r.push_back(e);
                end
            end
            s_rvalid_i = s_showing;
            s_rdata_i  = s_showing ? s_cur.data : $urandom;
            s_err_i    = s_showing && s_cur.err;
        end else begin
            s_rvalid_i = late_resp || (mphase != 2 && $urandom_range(0, 7) == 0);
            late_resp  = 0;
            s_rdata_i  = $urandom;
            s_err_i    = 1'($urandom_range(0, 1));
        end

        for (int i = 0; i < 2; i++) begin
            m_rready_i[i] = ($urandom_range(0, 3) != 0);
            if (mwait[i]) begin
                m_req_i[i] = 1'b0;
            end else if (m_req_i[i]) begin
                if (abort_en && $urandom_range(0, 31) == 0) m_req_i[i] = 1'b0;
            end else if ((i == 0) ? (mq0.size() > 0) : (mq1.size() > 0)) begin
                r = (i == 0) ? mq0.pop_front() : mq1.pop_front();
                m_addr_i[i]  = r.addr;
                m_we_i[i]    = r.we;
                m_be_i[i]    = r.be;
                m_wdata_i[i] = r.wdata;
                m_req_i[i]   = 1'b1;
            end
        end
    endtask

    // Observe phase: update the model with the handshakes that occur at the coming edge
    task automatic observe();
        case (mphase)
            0: begin
                if (m_req_i != 2'b00) begin
                    aexp_t a;
                    int w;
                    w = (m_req_i == 2'b11) ? pref : (m_req_i[1] ? 1 : 0);
                    a.mst = w; a.addr = m_addr_i[w]; a.we = m_we_i[w];
                    a.be = m_be_i[w]; a.wdata = m_wdata_i[w];
                    exp_a.push_back(a);
                    mown   = w;
                    mphase = 1;
                end
            end
            1: begin
                if (m_req_i[mown] && s_gnt_i) begin
                    mphase      = 2;
                    tcnt        = 0;
                    mwait[mown] = 1'b1;
                    s_busy      = 1;
                    s_showing   = 0;
                    if (sq.size() > 0) s_cur = sq.pop_front();
                    else s_cur = mk_plan(int'($urandom_range(0, 3)), $urandom,
                                         1'($urandom_range(0, 1)), 1'b0);
                    s_delay = s_cur.delay;
                end else if (!m_req_i[mown]) begin
                    mphase = 0;
                    if (exp_a.size() > 0) exp_a.delete(exp_a.size() - 1);
                end
            end
            2: begin
                if (s_rvalid_i && m_rready_i[mown]) begin
                    finish_txn();
                end
`ifdef OBI_ARB_TIMEOUT_EN
                else if (!s_rvalid_i) begin
                    tcnt++;
                    if (tcnt == TOUT_CYC) begin
                        rexp_t e;
                        e.mst = mown; e.data = BAD; e.err = 1'b1;
                        exp_r.push_back(e);
                        mphase = 3;
                    end
                end
`endif
            end
            3: begin
                if (m_rready_i[mown]) begin
                    finish_txn();
                    late_resp = 1;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        reset_ni   = 1'b0;
        m_req_i    = '0;
        m_addr_i   = '0;
        m_we_i     = '0;
        m_be_i     = '0;
        m_wdata_i  = '0;
        m_rready_i = '0;
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        s_err_i    = 1'b0;
        forever begin
            @(posedge clk); #1;
            drive();
            @(negedge clk); #1;
            if (reset_ni === 1'b1) observe();
        end
    end

    // Monitor: level checks against the model, then scoreboard pops on handshakes
    initial begin
        logic [1:0] oh;
        aexp_t a;
        rexp_t e;
        forever begin
            @(negedge clk);
            if (reset_ni === 1'b1) begin
                oh = (mown == 1) ? 2'b10 : 2'b01;
                check("s_req_o", 64'(s_req_o), (mphase == 1) ? 64'(m_req_i[mown]) : 64'd0);
                check("m_gnt_o", 64'(m_gnt_o), (mphase == 1 && s_gnt_i) ? 64'(oh) : 64'd0);
                check("s_rready_o", 64'(s_rready_o), (mphase == 2) ? 64'(m_rready_i[mown]) : 64'd1);
                check("m_rvalid_o", 64'(m_rvalid_o),
                      (mphase >= 2 && exp_r.size() > 0) ? 64'(oh) : 64'd0);
                if (mphase < 2) begin
                    check("idle_rdata", 64'(m_rdata_o), 64'd0);
                    check("idle_err", 64'(m_err_o), 64'd0);
                end
                if (s_req_o && s_gnt_i) begin
                    glog.push_back((m_gnt_o == 2'b10) ? 1 : 0);
                    if (exp_a.size() == 0) begin
                        check("aphase_unexpected", 64'd1, 64'd0);
                    end else begin
                        a = exp_a.pop_front();
                        check("a_gnt_owner", 64'(m_gnt_o), (a.mst == 1) ? 64'd2 : 64'd1);
                        check("a_addr", 64'(s_addr_o), 64'(a.addr));
                        check("a_we", 64'(s_we_o), 64'(a.we));
                        check("a_be", 64'(s_be_o), 64'(a.be));
                        check("a_wdata", 64'(s_wdata_o), 64'(a.wdata));
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    if (m_rvalid_o[i] && m_rready_i[i]) begin
                        if (exp_r.size() == 0) begin
                            check("resp_unexpected", 64'd1, 64'd0);
                        end else begin
                            e = exp_r.pop_front();
                            check("r_master", 64'(i), 64'(e.mst));
                            check("r_rdata", 64'(m_rdata_o), 64'(e.data));
                            check("r_err", 64'(m_err_o), 64'(e.err));
                        end
                    end
                end
            end
        end
    end

    task automatic sync();
        @(negedge clk); #2;
    endtask

    task automatic do_reset();
        sync();
        rst_req = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_s_req", 64'(s_req_o), 64'd0);
        check("rst_m_gnt", 64'(m_gnt_o), 64'd0);
        check("rst_m_rvalid", 64'(m_rvalid_o), 64'd0);
        check("rst_s_rready", 64'(s_rready_o), 64'd1);
        check("rst_m_err", 64'(m_err_o), 64'd0);
        #2;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n;
        n = 0;
        while (!bench_idle() && n < max_cyc) begin
            sync();
            n++;
        end
        checks++;
        if (!bench_idle()) begin
            errors++;
            $display("FAIL %s: not complete after %0d cycles (exp_a=%0d exp_r=%0d phase=%0d)",
                     name, n, exp_a.size(), exp_r.size(), mphase);
        end
    endtask

    initial begin
        int n;
        rst_req = 1;
        do_reset();

        // Single read from master 0
        glog.delete();
        mq0.push_back(mk_req(32'h4, 1'b0, 4'hF, '0));
        sq.push_back(mk_plan(1, 32'hDA7A5EAD, 1'b0, 1'b0));
        wait_idle(100, "m0_read");
        check("m0_read_grants", 64'(glog.size()), 64'd1);
        check("m0_read_owner", 64'(gl(0)), 64'd0);

        // After m0 completes, a tie goes to m1
        sync(); glog.delete();
        mq0.push_back(mk_req(32'h8, 1'b0, 4'hF, '0));
        mq1.push_back(mk_req(32'hC, 1'b0, 4'h3, '0));
        wait_idle(100, "prio_after_m0");
        check("prio_first", 64'(gl(0)), 64'd1);
        check("prio_second", 64'(gl(1)), 64'd0);

        // Both masters from reset: strict alternation
        do_reset(); glog.delete();
        mq0.push_back(mk_req(32'h10, 1'b0, 4'hF, '0));
        mq0.push_back(mk_req(32'h14, 1'b0, 4'hF, '0));
        mq1.push_back(mk_req(32'h2, 1'b1, 4'hF, 32'h1337C0DE));
        mq1.push_back(mk_req(32'h6, 1'b1, 4'hC, 32'hCAFEF00D));
        wait_idle(200, "alternation");
        for (int i = 0; i < 4; i++) check("alternation_order", 64'(gl(i)), 64'(i % 2));

        // Slave error response, other master waiting
        sync();
        mq1.push_back(mk_req(32'h20, 1'b0, 4'hF, '0));
        mq0.push_back(mk_req(32'h24, 1'b0, 4'hF, '0));
        sq.push_back(mk_plan(0, 32'hBADCAB1E, 1'b1, 1'b0));
        sq.push_back(mk_plan(2, 32'h0000_0001, 1'b0, 1'b0));
        wait_idle(100, "err_resp");

`ifdef OBI_ARB_TIMEOUT_EN
        // Slave never answers: timeout response, then a late stray response
        sync();
        mq0.push_back(mk_req(32'h40, 1'b0, 4'hF, '0));
        sq.push_back(mk_plan(0, 32'h1234_5678, 1'b0, 1'b1));
        wait_idle(100, "timeout");
        repeat (4) sync();
`endif

        // Reset while waiting for the response, then a fresh m1 request
        sync();
        mq0.push_back(mk_req(32'h30, 1'b0, 4'hF, '0));
        sq.push_back(mk_plan(6, 32'h5555_AAAA, 1'b0, 1'b0));
        n = 0;
        while (mphase != 2 && n < 100) begin
            sync();
            n++;
        end
        check("reach_resp", 64'(mphase), 64'd2);
        do_reset(); glog.delete();
        mq1.push_back(mk_req(32'h34, 1'b1, 4'hF, 32'h0BAD_F00D));
        wait_idle(100, "after_reset");
        check("after_reset_owner", 64'(gl(0)), 64'd1);

        // Random traffic with aborts and stray responses
        sync();
        rand_en  = 1;
        abort_en = 1;
        repeat (800) sync();
        rand_en  = 0;
        abort_en = 0;
        wait_idle(500, "random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/obi_arbiter_2.md
OBI_ARBITER_2 -- requirements
Module: obi_arbiter_2

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width on all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width, multiple of 8.
REQ-003 SHALL have parameter TIMEOUT, default 16: response-timeout cycle limit, 1..255; used only under OBI_ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk_i  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset_ni  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port m_req_i  in  [1:0]  per-master OBI request.
REQ-007 SHALL have port m_gnt_o  out  [1:0]  per-master OBI grant.
REQ-008 SHALL have port m_addr_i  in  [1:0][ADDR_WIDTH-1:0]  per-master address.
REQ-009 SHALL have port m_we_i  in  [1:0]  per-master write enable.
REQ-010 SHALL have port m_be_i  in  [1:0][DATA_WIDTH/8-1:0]  per-master byte enables.
REQ-011 SHALL have port m_wdata_i  in  [1:0][DATA_WIDTH-1:0]  per-master write data.
REQ-012 SHALL have port m_rvalid_o  out  [1:0]  per-master response valid.
REQ-013 SHALL have port m_rready_i  in  [1:0]  per-master response ready.
REQ-014 SHALL have port m_rdata_o  out  DATA_WIDTH  shared read data, qualified by m_rvalid_o.
REQ-015 SHALL have port m_err_o  out  1  shared error flag, qualified by m_rvalid_o.
REQ-016 SHALL have ports s_req_o out 1, s_gnt_i in 1, s_addr_o out ADDR_WIDTH, s_we_o out 1, s_be_o out DATA_WIDTH/8, s_wdata_o out DATA_WIDTH: slave A-channel.
REQ-017 SHALL have ports s_rvalid_i in 1, s_rready_o out 1, s_rdata_i in DATA_WIDTH, s_err_i in 1: slave R-channel.

Function
REQ-018 SHALL use FSM states IDLE, ADDR, RESP (TOUT also exists under OBI_ARB_TIMEOUT_EN), with one outstanding transaction at most.
REQ-019 IDLE: on any m_req_i, SHALL register owner and go to ADDR next cycle; single requester wins; both requesting -> master indicated by prio bit wins.
REQ-020 ADDR: SHALL drive s_req_o=m_req_i[owner] and s_addr/we/be/wdata from owner inputs; m_gnt_o[owner]=s_gnt_i; non-owner gnt=0.
REQ-021 ADDR with s_req_o&&s_gnt_i SHALL move to RESP; owner dropping req before gnt SHALL return to IDLE with prio unchanged.
REQ-022 RESP: SHALL drive s_req_o=0, m_rvalid_o[owner]=s_rvalid_i, s_rready_o=m_rready_i[owner], m_rdata_o=s_rdata_i, m_err_o=s_err_i.
REQ-023 RESP with s_rvalid_i&&s_rready_o SHALL return to IDLE and set prio to the non-owner master.
REQ-024 Outside RESP/TOUT: s_rready_o=1 (stray responses discarded, never forwarded); m_rvalid_o=0, m_rdata_o=0, m_err_o=0.
REQ-025 Minimum latency, req to s_req_o: 1 cycle; back-to-back transactions: 1 IDLE cycle between them.
REQ-026 Non-owner request SHALL be held off (gnt=0) indefinitely until the owner completes; no data from the non-owner SHALL reach the slave.

Reset
REQ-027 reset_ni low at a rising edge SHALL force IDLE, prio=0 (master 0 preferred), counter=0, all m_gnt_o/m_rvalid_o/s_req_o=0, s_rready_o=1, even mid-transaction.
REQ-028 A transaction interrupted by reset SHALL be abandoned with no response to either master.

Configuration
REQ-029 With OBI_ARB_TIMEOUT_EN defined: cycle counter SHALL clear on RESP entry and increment each RESP cycle without s_rvalid_i; reaching TIMEOUT SHALL enter TOUT.
REQ-030 TOUT SHALL drive m_rvalid_o[owner]=1, m_rdata_o='hBADCAB1E (truncated/zero-extended to DATA_WIDTH), m_err_o=1, s_rready_o=1; on m_rready_i[owner] -> IDLE, prio flipped. Without macro: no counter, no TOUT, RESP waits forever.

Structure
REQ-031 Package obi_arb_pkg SHALL hold the state enum type and the BAD_DATA constant 'hBADCAB1E.
REQ-032 SHALL instantiate one sub-module obi_rr_arb (2-way round-robin pick: inputs req[1:0], prio; output winner index).

Verification
REQ-033 Reset: reset_ni=0 one cycle -> state IDLE, prio=0, s_req_o=0, s_rready_o=1.
REQ-034 Only m0 reads 0x4, slave returns 'hDA7A5EAD -> m_gnt_o=01 with s_gnt_i, m_rvalid_o=01, m_rdata_o='hDA7A5EAD, prio=1.
REQ-035 m0 and m1 both request from reset -> m0 served first, then m1 (m1 write 'h1337C0DE to 0x2 reaches s_wdata_o), then m0 again: strict alternation over 4 transactions.
REQ-036 Slave returns s_err_i=1, s_rdata_i='hBADCAB1E -> owner sees m_err_o=1, same data; other master sees m_rvalid_o=0.
REQ-037 OBI_ARB_TIMEOUT_EN, TIMEOUT=4, slave never responds -> 4 cycles after RESP entry m_rvalid_o[owner]=1, m_err_o=1, m_rdata_o='hBADCAB1E; later stray s_rvalid_i is discarded.
REQ-038 reset_ni=0 during RESP -> IDLE next cycle, no m_rvalid_o pulse, then a fresh m1 request is served normally.
